// File: rtl/binary16_mul_iterative.sv
// Iterative binary16 multiplier: 11-cycle shift-and-add significand multiply,
// one normalise cycle, fixed 12-cycle latency, truncating, no special cases.
module binary16_mul_iterative #(
  parameter int MANT_W = 11
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        data_valid_in,
  output logic [15:0] result,
  output logic        data_valid_out,
  output logic        busy
);

  localparam int FRAC_W = MANT_W - 1;
  localparam int PROD_W = 2 * MANT_W;
  localparam int STEP_W = $clog2(MANT_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MANT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    NORM
  } state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   finish;

  logic [STEP_W-1:0] step_q;
  logic [PROD_W-1:0] prod_q;
  logic [PROD_W-1:0] mcand_q;
  logic [MANT_W-1:0] mplier_q;
  logic              sign_q;
  logic              zero_q;
  logic [4:0]        exp_base_q;

  logic [4:0]        exp_base_d;
  logic              zero_d;
  logic              prod_msb;
  logic [FRAC_W-1:0] norm_frac;
  logic [4:0]        norm_exp;
  logic [15:0]       result_d;

  // Subtracting the bias in 5 bits wraps modulo 32, which is the intended
  // behaviour: exponent overflow/underflow is not detected.
  assign exp_base_d = a[14:10] + b[14:10] - 5'd15;
  assign zero_d     = (a[14:0] == 15'd0) || (b[14:0] == 15'd0);

  assign prod_msb  = prod_q[PROD_W-1];
  assign norm_frac = prod_msb ? prod_q[PROD_W-2 -: FRAC_W] : prod_q[PROD_W-3 -: FRAC_W];
  assign norm_exp  = exp_base_q + {4'd0, prod_msb};
  assign result_d  = zero_q ? {sign_q, 15'd0} : {sign_q, norm_exp, norm_frac};

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_valid_in) begin
          accept  = 1'b1;
          state_d = MULT;
        end
      end
      MULT: begin
        if (step_q == LAST_STEP) begin
          state_d = NORM;
        end
      end
      NORM: begin
        finish = 1'b1;
        // The completion edge may also start the next operation.
        if (data_valid_in) begin
          accept  = 1'b1;
          state_d = MULT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // here samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      // NOTE: the datapath registers are cleared too, not just the control, so an
      // aborted operation leaves nothing behind that a later one could observe.
      step_q         <= '0;
      prod_q         <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      sign_q         <= 1'b0;
      zero_q         <= 1'b0;
      exp_base_q     <= '0;
      result         <= 16'h0000;
      data_valid_out <= 1'b0;
      busy           <= 1'b0;
    end else begin
      if (accept) begin
        step_q     <= '0;
        prod_q     <= '0;
        mcand_q    <= {{(PROD_W-MANT_W){1'b0}}, 1'b1, a[FRAC_W-1:0]};
        mplier_q   <= {1'b1, b[FRAC_W-1:0]};
        sign_q     <= a[15] ^ b[15];
        zero_q     <= zero_d;
        exp_base_q <= exp_base_d;
      end else if (state_q == MULT) begin
        // One multiplier bit per cycle, LSB first.
        if (mplier_q[0]) begin
          prod_q <= prod_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        step_q   <= step_q + STEP_W'(1);
      end

      if (finish) begin
        result <= result_d;
      end
      data_valid_out <= finish;
      busy           <= accept | (busy & ~finish);
    end
  end

endmodule

// File: tb/tb_binary16_mul_iterative.sv
// Self-checking bench: directed literal cases plus randomized traffic compared
// every cycle against an integer-arithmetic reference model.
module tb_binary16_mul_iterative;

  logic        clk_in;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        data_valid_in;
  logic [15:0] result;
  logic        data_valid_out;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 0;

  binary16_mul_iterative #(.MANT_W(11)) dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .a              (a),
    .b              (b),
    .data_valid_in  (data_valid_in),
    .result         (result),
    .data_valid_out (data_valid_out),
    .busy           (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product from the number-format rules, using plain integers.
  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    int   ma, mb, p, e, frac;
    logic s;
    s = x[15] ^ y[15];
    if (x[14:0] == 15'd0 || y[14:0] == 15'd0) return {s, 15'd0};
    ma = 1024 + int'(x[9:0]);
    mb = 1024 + int'(y[9:0]);
    p  = ma * mb;
    e  = int'(x[14:10]) + int'(y[14:10]) - 15;
    if (p >= (1 << 21)) begin
      e    = e + 1;
      frac = (p >> 11) % 1024;
    end else begin
      frac = (p >> 10) % 1024;
    end
    e = ((e % 32) + 32) % 32;
    return {s, 5'(e), 10'(frac)};
  endfunction

  // Transaction-level model: remaining cycles of the operation in flight.
  int          m_cnt = 0;
  logic [15:0] m_pending = 16'h0;
  logic [15:0] m_res = 16'h0;
  logic        m_dv = 1'b0;
  logic        m_busy = 1'b0;

  always @(posedge clk_in) begin
    if (!rst) begin
      m_cnt  = 0;
      m_res  = 16'h0;
      m_dv   = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_dv = 1'b0;
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_dv   = 1'b1;
          m_res  = m_pending;
          m_busy = 1'b0;
        end
      end
      if (m_cnt == 0 && data_valid_in) begin
        m_pending = ref_mul(a, b);
        m_cnt     = 12;
        m_busy    = 1'b1;
      end
    end
  end

  always @(negedge clk_in) begin
    if (cmp_en) begin
      check("cyc data_valid_out", 32'(data_valid_out), 32'(m_dv));
      check("cyc busy", 32'(busy), 32'(m_busy));
      check("cyc result", 32'(result), 32'(m_res));
    end
  end

  task automatic pulse(input logic [15:0] x, input logic [15:0] y);
    a = x;
    b = y;
    data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
  endtask

  task automatic expect_op(input string name, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] exp);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 0;
    pulse(x, y);
    while (!seen && cyc < 20) begin
      @(negedge clk_in);
      cyc++;
      if (data_valid_out) seen = 1;
    end
    check({name, " latency"}, 32'(cyc), 32'd12);
    check({name, " result"}, 32'(result), 32'(exp));
  endtask

  initial begin
    int dv_count;
    rst = 1'b0;
    data_valid_in = 1'b0;
    a = 16'h0;
    b = 16'h0;
    @(negedge clk_in);
    @(negedge clk_in);
    check("reset result", 32'(result), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset data_valid_out", 32'(data_valid_out), 32'h0);
    cmp_en = 1;
    rst = 1'b1;
    @(negedge clk_in);

    expect_op("2*3", 16'h4000, 16'h4200, 16'h4600);
    expect_op("1.5*1.5", 16'h3E00, 16'h3E00, 16'h4080);
    expect_op("-2*3", 16'hC000, 16'h4200, 16'hC600);
    expect_op("trunc", 16'h3C01, 16'h3C01, 16'h3C02);
    expect_op("negzero", 16'h8000, 16'h4200, 16'h8000);
    expect_op("zero", 16'h0000, 16'h4200, 16'h0000);

    // Second pulse while busy must be dropped.
    pulse(16'h4000, 16'h4200);
    repeat (4) @(negedge clk_in);
    pulse(16'h3E00, 16'h3E00);
    dv_count = 0;
    repeat (24) begin
      @(negedge clk_in);
      if (data_valid_out) dv_count++;
    end
    check("ignored pulse outputs", 32'(dv_count), 32'd1);
    check("ignored pulse result", 32'(result), 32'h4600);

    // Pulse on the completion edge is accepted back-to-back.
    pulse(16'h3E00, 16'h3E00);
    repeat (11) @(negedge clk_in);
    pulse(16'h4000, 16'h4200);
    check("b2b first dv", 32'(data_valid_out), 32'd1);
    check("b2b first result", 32'(result), 32'h4080);
    check("b2b busy kept", 32'(busy), 32'd1);
    repeat (12) @(negedge clk_in);
    check("b2b second dv", 32'(data_valid_out), 32'd1);
    check("b2b second result", 32'(result), 32'h4600);
    @(negedge clk_in);

    // Reset mid-operation aborts without output.
    pulse(16'h4000, 16'h4200);
    repeat (5) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    rst = 1'b1;
    check("abort result", 32'(result), 32'h0);
    check("abort busy", 32'(busy), 32'h0);
    dv_count = 0;
    repeat (15) begin
      @(negedge clk_in);
      if (data_valid_out) dv_count++;
    end
    check("abort outputs", 32'(dv_count), 32'd0);
    expect_op("after abort", 16'hC000, 16'h4200, 16'hC600);

    // Randomized traffic with occasional zeros and resets.
    repeat (1500) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 9) == 0) a[14:0] = 15'd0;
      if ($urandom_range(0, 9) == 0) b[14:0] = 15'd0;
      data_valid_in = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 149) != 0);
      @(negedge clk_in);
    end
    rst = 1'b1;
    data_valid_in = 1'b0;
    repeat (15) @(negedge clk_in);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
